// File: rtl/axil_cmd_sequencer.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out.
// Optional watchdog enabled by defining AXIL_SEQ_TIMEOUT_EN; after a timeout the block halts until reset.
module axil_cmd_sequencer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                   clk_0,
  input  logic                   rst_0,
  // command stream
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  input  logic [DATA_W/8-1:0]    cmd_wstrb,
  // result stream
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic                   rsp_timeout,
  // AXI4-Lite master
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [ADDR_W-1:0]      m_axi_awaddr,
  output logic [2:0]             m_axi_awprot,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  output logic [DATA_W-1:0]      m_axi_wdata,
  output logic [DATA_W/8-1:0]    m_axi_wstrb,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  input  logic [1:0]             m_axi_bresp,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  output logic [ADDR_W-1:0]      m_axi_araddr,
  output logic [2:0]             m_axi_arprot,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  input  logic [DATA_W-1:0]      m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  // status
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic                   busy
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("DATA_W must be 32 or 64");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP, S_HALT
  } state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  assign cmd_hs = cmd_valid && cmd_ready_q;
  assign aw_hs  = awvalid_q && m_axi_awready;
  assign w_hs   = wvalid_q  && m_axi_wready;
  assign b_hs   = bready_q  && m_axi_bvalid;
  assign ar_hs  = arvalid_q && m_axi_arready;
  assign r_hs   = rready_q  && m_axi_rvalid;
  assign rsp_hs = rsp_valid_q && rsp_ready;

`ifdef AXIL_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            wait_st, to_hit;

  assign wait_st = (state_q == S_WR) || (state_q == S_WR_RESP) ||
                   (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
  assign to_hit  = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d     = state_q;
    // Each valid/ready drops after its own handshake in any state, so a
    // timed-out transaction never retracts a valid before the slave takes it.
    awvalid_d   = awvalid_q && !aw_hs;
    wvalid_d    = wvalid_q  && !w_hs;
    bready_d    = bready_q  && !b_hs;
    arvalid_d   = arvalid_q && !ar_hs;
    rready_d    = rready_q  && !r_hs;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    err_cnt_d   = err_cnt_q;
`ifdef AXIL_SEQ_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif

    if (((b_hs && m_axi_bresp != 2'b00) || (r_hs && m_axi_rresp != 2'b00)) &&
        (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end
        end
      end
      S_WR: begin
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs))
          state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (b_hs) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
        end
      end
      S_RD_ADDR: begin
        if (ar_hs)
          state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (r_hs) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = m_axi_rresp;
          rsp_rdata_d = m_axi_rdata;
        end
      end
      S_RSP: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
`ifdef AXIL_SEQ_TIMEOUT_EN
          state_d     = rsp_timeout_q ? S_HALT : S_IDLE;
`else
          state_d     = S_IDLE;
`endif
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

`ifdef AXIL_SEQ_TIMEOUT_EN
    // Real progress on the last allowed cycle wins over the timeout.
    if (wait_st && (state_d == state_q) && to_hit) begin
      state_d       = S_RSP;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = 2'b11;
      rsp_rdata_d   = '0;
    end
    to_cnt_d = (wait_st && (state_d == state_q)) ? to_cnt_q + TO_W'(1) : '0;
`endif

    // Registered so cmd_ready rises on the first edge out of reset.
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_0 or posedge rst_0) begin
    if (rst_0) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

`ifdef AXIL_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_0 or posedge rst_0) begin
    if (rst_0) begin
      to_cnt_q      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = rready_q;
  assign err_cnt       = err_cnt_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_axil_cmd_sequencer.sv
// Bench for axil_cmd_sequencer: directed + randomized commands against a delay-configurable slave.
// Expected responses come from a command-level model (write -> bresp/0, read -> rresp/rdata, saturating error count).
module tb_axil_cmd_sequencer;
  localparam int ERR_W = 3;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic        clk_0 = 1'b0;
  logic        rst_0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic [1:0]  bresp, rresp;
  logic [ERR_W-1:0] err_cnt;
  logic        busy;

  axil_cmd_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8), .ERR_CNT_W(ERR_W)) dut (
    .clk_0(clk_0), .rst_0(rst_0),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk_0 = ~clk_0;

  int cyc = 0;
  always @(posedge clk_0) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // slave knobs and observations
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  bit          b_never;
  logic [1:0]  slv_bresp, slv_rresp;
  logic [31:0] slv_rdata;
  int          aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
  int          aw_hs_cyc, w_hs_cyc;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_prot;

  initial begin
    bit aw_got, w_got, pend_b, pend_r;
    int aw_w, w_w, b_w, ar_w, r_w;
    aw_got = 0; w_got = 0; pend_b = 0; pend_r = 0;
    aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; cap_prot = 0;
    forever begin
      @(negedge clk_0);
      if (rst_0) begin
        aw_got = 0; w_got = 0; pend_b = 0; pend_r = 0;
      end else begin
        if (awvalid && awready) begin
          cap_awaddr = awaddr; cap_prot = cap_prot | awprot; aw_n++; aw_got = 1; aw_hs_cyc = cyc;
        end
        if (wvalid && wready) begin
          cap_wdata = wdata; cap_wstrb = wstrb; w_n++; w_got = 1; w_hs_cyc = cyc;
        end
        if (aw_got && w_got) begin pend_b = 1; aw_got = 0; w_got = 0; b_w = 0; end
        if (bvalid && bready) begin b_n++; pend_b = 0; end
        if (arvalid && arready) begin
          cap_araddr = araddr; cap_prot = cap_prot | arprot; ar_n++; pend_r = 1; r_w = 0;
        end
        if (rvalid && rready) begin r_n++; pend_r = 0; end
      end
      @(posedge clk_0); #1;
      if (rst_0) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
      end else begin
        if (awvalid) begin awready = (aw_w >= aw_dly); aw_w++; end else begin awready = 0; aw_w = 0; end
        if (wvalid)  begin wready  = (w_w  >= w_dly);  w_w++;  end else begin wready  = 0; w_w  = 0; end
        if (arvalid) begin arready = (ar_w >= ar_dly); ar_w++; end else begin arready = 0; ar_w = 0; end
        bvalid = pend_b && !b_never && (b_w >= b_dly);
        if (pend_b) b_w++;
        bresp  = slv_bresp;
        rvalid = pend_r && (r_w >= r_dly);
        if (pend_r) r_w++;
        rdata  = rvalid ? slv_rdata : 32'h0;
        rresp  = slv_rresp;
      end
    end
  end

  // Any valid that drops or changes payload before its handshake counts as a violation.
  int stab_err = 0;
  initial begin
    bit p_ok, p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs, p_rv, p_rhs, p_to;
    logic [31:0] p_awa, p_wd, p_ara, p_rd;
    logic [3:0]  p_ws;
    logic [1:0]  p_rs;
    p_ok = 0;
    forever begin
      @(negedge clk_0);
      if (!rst_0 && p_ok) begin
        if (p_awv && !p_awhs && (!awvalid || awaddr !== p_awa)) stab_err++;
        if (p_wv && !p_whs && (!wvalid || wdata !== p_wd || wstrb !== p_ws)) stab_err++;
        if (p_arv && !p_arhs && (!arvalid || araddr !== p_ara)) stab_err++;
        if (p_rv && !p_rhs && (!rsp_valid || rsp_rdata !== p_rd || rsp_resp !== p_rs ||
                               rsp_timeout !== p_to)) stab_err++;
      end
      p_ok = !rst_0;
      p_awv = awvalid; p_awhs = awvalid && awready; p_awa = awaddr;
      p_wv = wvalid; p_whs = wvalid && wready; p_wd = wdata; p_ws = wstrb;
      p_arv = arvalid; p_arhs = arvalid && arready; p_ara = araddr;
      p_rv = rsp_valid; p_rhs = rsp_valid && rsp_ready;
      p_rd = rsp_rdata; p_rs = rsp_resp; p_to = rsp_timeout;
    end
  end

  logic [ERR_W-1:0] exp_err = '0;

  task automatic set_slave(input int a, input int w, input int b, input int ar, input int r);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int acc);
    int n;
    @(posedge clk_0); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    @(negedge clk_0);
    while (!cmd_ready && n < 20) begin @(negedge clk_0); n++; end
    chk("cmd_accept", cmd_ready, 1'b1);
    acc = cyc;
    @(posedge clk_0); #1;
    // scramble the bus so only latched values can reach AXI
    cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int rdly, input bit chk_lat);
    int n, acc, hold_err, aw0, w0, b0, ar0, r0;
    logic [31:0] erd;
    logic [1:0]  ersp;
    aw0 = aw_n; w0 = w_n; b0 = b_n; ar0 = ar_n; r0 = r_n;
    erd  = wr ? 32'h0 : slv_rdata;
    ersp = wr ? slv_bresp : slv_rresp;
    if (ersp != 2'b00 && exp_err != ERR_MAX) exp_err++;
    send_cmd(wr, addr, data, strb, acc);
    n = 0;
    @(negedge clk_0);
    while (!rsp_valid && n < 200) begin @(negedge clk_0); n++; end
    chk("rsp_valid", rsp_valid, 1'b1);
    if (chk_lat) chk("wr_latency", 64'(cyc - acc), 64'd3);
    chk("rsp_rdata", rsp_rdata, erd);
    chk("rsp_resp", rsp_resp, ersp);
    chk("rsp_timeout", rsp_timeout, 1'b0);
    chk("err_cnt", err_cnt, exp_err);
    chk("busy_rsp", busy, 1'b1);
    hold_err = 0;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk_0);
      if (cmd_ready || !rsp_valid) hold_err++;
    end
    @(posedge clk_0); #1; rsp_ready = 1;
    @(negedge clk_0);
    if (cmd_ready) hold_err++;
    @(posedge clk_0); #1; rsp_ready = 0;
    @(negedge clk_0);
    chk("rsp_hold", hold_err, 0);
    chk("cmd_ready_next", cmd_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("rsp_dropped", rsp_valid, 1'b0);
    if (wr) begin
      chk("aw_beats", aw_n - aw0, 1); chk("w_beats", w_n - w0, 1); chk("b_beats", b_n - b0, 1);
      chk("ar_beats_wr", ar_n - ar0, 0);
      chk("awaddr", cap_awaddr, addr); chk("wdata", cap_wdata, data); chk("wstrb", cap_wstrb, strb);
    end else begin
      chk("ar_beats", ar_n - ar0, 1); chk("r_beats", r_n - r0, 1);
      chk("aw_beats_rd", aw_n - aw0, 0);
      chk("araddr", cap_araddr, addr);
    end
    chk("prot_zero", cap_prot, 3'b000);
    chk("axi_stable", stab_err, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk_0); rst_0 = 1; #1;
    chk("rst_arvalid", arvalid, 1'b0); chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);   chk("rst_bready", bready, 1'b0);
    chk("rst_rready", rready, 1'b0);   chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0); chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_resp", rsp_resp, 2'b00);  chk("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_err_cnt", err_cnt, 0);    chk("rst_busy", busy, 1'b0);
    exp_err = '0;
    repeat (2) @(negedge clk_0);
    rst_0 = 0; #1;
    chk("cmd_ready_pre_edge", cmd_ready, 1'b0);
    @(posedge clk_0); #1;
    chk("cmd_ready_first_edge", cmd_ready, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n, bad;
    rst_0 = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0; b_never = 0; slv_bresp = 0; slv_rresp = 0; slv_rdata = 0;
    set_slave(0, 0, 0, 0, 0);
    #1;
    chk("init_cmd_ready", cmd_ready, 1'b0); chk("init_busy", busy, 1'b0);
    chk("init_err_cnt", err_cnt, 0);        chk("init_awvalid", awvalid, 1'b0);
    chk("init_arvalid", arvalid, 1'b0);     chk("init_rsp_valid", rsp_valid, 1'b0);
    repeat (3) @(negedge clk_0);
    rst_0 = 0; #1;
    chk("cmd_ready_pre_edge", cmd_ready, 1'b0);
    @(posedge clk_0); #1;
    chk("cmd_ready_first_edge", cmd_ready, 1'b1);

    // zero-wait OKAY write
    run_cmd(1, 32'h10, 32'h0000_0E9E, 4'hF, 0, 1);

    // AW stalled 4 cycles, W immediate
    set_slave(4, 0, 0, 0, 0);
    run_cmd(1, 32'h20, 32'h1234_5678, 4'h3, 0, 0);
    chk("w_before_aw", w_hs_cyc < aw_hs_cyc, 1'b1);

    // SLVERR read
    set_slave(0, 0, 0, 0, 0);
    slv_rdata = 32'hDEAD_BEEF; slv_rresp = 2'b10;
    chk("err_before_slverr", err_cnt, 0);
    run_cmd(0, 32'h14, 32'h0, 4'h0, 0, 0);

    // slow response consumer
    slv_rdata = 32'hCAFE_0001; slv_rresp = 2'b00;
    run_cmd(0, 32'h18, 32'h0, 4'h0, 5, 0);

    // reset while arvalid is waiting
    set_slave(0, 0, 0, 12, 0);
    send_cmd(0, 32'h40, 32'h0, 4'h0, acc);
    repeat (2) @(negedge clk_0);
    chk("arvalid_pre_rst", arvalid, 1'b1);
    pulse_reset();
    bad = 0;
    for (n = 0; n < 15; n++) begin @(negedge clk_0); if (rsp_valid) bad++; end
    chk("no_rsp_after_rst", bad, 0);
    chk("err_after_rst", err_cnt, 0);
    set_slave(0, 0, 0, 0, 0); slv_bresp = 2'b00;
    run_cmd(1, 32'h44, 32'hA5A5_5A5A, 4'hC, 0, 1);

    // drive the error counter into saturation
    slv_bresp = 2'b11;
    for (int i = 0; i < 9; i++) run_cmd(1, 32'h100 + 32'(i * 4), $urandom, 4'hF, 0, 0);
    chk("err_saturated", err_cnt, ERR_MAX);
    pulse_reset();

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      slv_bresp = 2'($urandom_range(0, 3));
      slv_rresp = 2'($urandom_range(0, 3));
      slv_rdata = $urandom;
      run_cmd(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 3), 0);
    end

`ifdef AXIL_SEQ_TIMEOUT_EN
    // B never arrives: watchdog answers, then the block halts until reset
    set_slave(0, 0, 0, 0, 0); b_never = 1;
    send_cmd(1, 32'h80, 32'h55, 4'hF, acc);
    n = 0;
    @(negedge clk_0);
    while (!rsp_valid && n < 60) begin @(negedge clk_0); n++; end
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_flag", rsp_timeout, 1'b1);
    chk("to_resp", rsp_resp, 2'b11);
    @(posedge clk_0); #1; rsp_ready = 1;
    @(posedge clk_0); #1; rsp_ready = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk_0); if (cmd_ready || !busy) bad++; end
    chk("halt_no_ready", bad, 0);
    b_never = 0;
    pulse_reset();
    slv_bresp = 2'b00;
    run_cmd(1, 32'h84, 32'h66, 4'hF, 0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axil_cmd_sequencer.md
AXIL_CMD_SEQUENCER -- requirements
Module: axil_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width, 32 or 64; WSTRB width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024: maximum wait cycles per transaction, >=2.
REQ-004 SHALL have parameter ERR_CNT_W, default 16: width of the error counter.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk_0, input, 1: sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_0, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_write (in, 1), cmd_addr (in, ADDR_W), cmd_wdata (in, DATA_W) and cmd_wstrb (in, DATA_W/8): command stream.
REQ-009 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_rdata (out, DATA_W), rsp_resp (out, 2) and rsp_timeout (out, 1): result stream.
REQ-010 SHALL have a full AXI4-Lite master port set m_axi_aw*, w*, b*, ar*, r* (valid/ready, addr, data, strb, resp); AWPROT and ARPROT are tied to 0.
REQ-011 SHALL have port err_cnt, out, ERR_CNT_W: count of non-OKAY responses.
REQ-012 SHALL have port busy, out, 1: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP and HALT.
REQ-014 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready it SHALL latch the command and go to WR if cmd_write=1, else to RD_ADDR.
REQ-015 SHALL make awvalid, wvalid and bready all 1 in the cycle after write acceptance.
REQ-016 In WR, awvalid SHALL clear on the cycle after its handshake and wvalid likewise, independently and in either order; when both handshakes occur in the same cycle, both SHALL clear together.
REQ-017 SHALL move from WR to WR_RESP once both AW and W handshakes have completed.
REQ-018 SHALL hold bready at 1 until the B handshake, then clear it and go to RSP, latching bresp into rsp_resp and setting rsp_rdata to 0.
REQ-019 SHALL assert arvalid in the cycle after read acceptance, hold it to the AR handshake, then go to RD_DATA.
REQ-020 SHALL hold rready at 1 from read acceptance until the R handshake; on the handshake it SHALL latch rdata and rresp and go to RSP.
REQ-021 SHALL hold rsp_valid at 1 in RSP until rsp_ready, then return to IDLE; minimum command-to-command spacing is 1 cycle (the IDLE cycle).
REQ-022 SHALL hold every valid and its payload stable until the handshake completes (AXI-compliant).
REQ-023 SHALL increment err_cnt on each B or R handshake with resp!=2'b00, saturating at all-ones.
REQ-024 Minimum write latency, acceptance to rsp_valid with zero-wait slave: 3 cycles.

Reset
REQ-025 While rst_0=1, all of the following SHALL hold immediately, independent of clk_0: state=IDLE, all valids/readies=0, cmd_ready=0, rsp_*=0, err_cnt=0, busy=0.
REQ-026 SHALL set cmd_ready=1 on the first clk_0 edge after rst_0 deasserts.
REQ-027 On reset mid-transaction, the pending transaction SHALL be abandoned and no response emitted.

Configuration
REQ-028 SHALL use the macro AXIL_SEQ_TIMEOUT_EN to include or exclude the timeout watchdog.
REQ-029 With AXIL_SEQ_TIMEOUT_EN defined: a counter SHALL run in WR, WR_RESP, RD_ADDR and RD_DATA and clear on each state entry.
REQ-030 With the watchdog enabled, on reaching TIMEOUT_CYC the block SHALL emit rsp_valid=1 with rsp_timeout=1 and rsp_resp=2'b11.
REQ-031 After a timeout, AXI valids SHALL be held unchanged (no retraction); once rsp is accepted the FSM SHALL enter HALT, with cmd_ready=0 until reset.
REQ-032 Without AXIL_SEQ_TIMEOUT_EN: the FSM SHALL wait indefinitely, rsp_timeout SHALL be tied to 0, HALT SHALL be unreachable, and no counter logic SHALL be generated.

Verification
REQ-033 Write addr 0x10, data 3742 (0xE9E), strb 0xF, zero-wait slave, OKAY -> one AW/W beat carries those values; rsp_resp=0; rsp_rdata=0; rsp_valid 3 cycles after acceptance.
REQ-034 Write with awready delayed 4 cycles and wready immediate -> wvalid drops first; awvalid holds until its handshake; exactly one B handshake.
REQ-035 Read addr 0x14, slave returns 0xDEADBEEF with SLVERR -> rsp_rdata=0xDEADBEEF; rsp_resp=2; err_cnt 0->1.
REQ-036 Assert rsp_ready only 5 cycles after rsp_valid -> rsp fields stable throughout; cmd_ready=0 until the cycle after acceptance.
REQ-037 AXIL_SEQ_TIMEOUT_EN, TIMEOUT_CYC=8, slave never raises bvalid -> rsp_timeout=1, rsp_resp=3; after rsp accepted, cmd_ready stays 0 until rst_0.
REQ-038 Assert rst_0 mid-read while arvalid=1 -> arvalid=0 immediately; no rsp; err_cnt=0; the next command completes normally.
